// File: rtl/data_to_segments_if.sv
// Display bus: Data from the generator, segment/anode drive and Busy back.
// master drives Data; slave (the display stage) drives Segments, Anodes, Busy.
interface data_to_segments_if #(
  parameter int Size   = 5,
  parameter int Digits = 3
);
  logic [Size-1:0]   Data;
  logic [6:0]        Segments;
  logic [Digits-1:0] Anodes;
  logic              Busy;

  modport master (
    output Data,
    input  Segments,
    input  Anodes,
    input  Busy
  );

  modport slave (
    input  Data,
    output Segments,
    output Anodes,
    output Busy
  );
endinterface

// File: rtl/data_to_segments.sv
// data_to_segments: Data -> decimal via serial double-dabble, then a
// multiplexed common-anode 7-seg scan. Ports: Clock, Reset (async, high),
// bus (slave: Data in; Segments/Anodes/Busy out, all registered).
// Option: LEADING_ZERO_BLANK_EN blanks numeric digits above the top non-zero.
module data_to_segments #(
  parameter int    Size             = 5,
  parameter string Signed           = "Yes",
  parameter int    Digits           = 3,
  parameter int    ClockPeriod_ns   = 20,
  parameter int    RefreshPeriod_ns = 1_000_000
) (
  input  logic              Clock,
  input  logic              Reset,
  data_to_segments_if.slave bus
);

  localparam bit IsSigned = (Signed == "Yes");
  // The sign digit, when present, takes no BCD nibble.
  localparam int NumDig  = IsSigned ? Digits - 1 : Digits;
  localparam int BcdW    = 4 * NumDig;
  localparam int TickRaw = RefreshPeriod_ns / ClockPeriod_ns;
  localparam int Tick    = (TickRaw < 1) ? 1 : TickRaw;
  localparam int PreW    = (Tick > 1) ? $clog2(Tick) : 1;
  localparam int IdxW    = (Digits > 1) ? $clog2(Digits) : 1;
  localparam int CntW    = $clog2(Size + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } state_t;

  state_t          state_q;
  logic            valid_q;
  logic            neg_q;
  logic            disp_neg_q;
  logic            data_neg;
  logic [Size-1:0] shadow_q;
  logic [Size-1:0] mag_q;
  logic [BcdW-1:0] bcd_q;
  logic [BcdW-1:0] bcd_adj;
  logic [BcdW-1:0] disp_bcd_q;
  logic [CntW-1:0] cnt_q;

  logic [PreW-1:0] pre_q;
  logic [IdxW-1:0] idx_q;
  logic [NumDig-1:0] lz_mask;
  logic [6:0]      seg_sel;

  assign data_neg = IsSigned && bus.Data[Size-1];

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Double-dabble correction applied before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NumDig; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      neg_q      <= 1'b0;
      shadow_q   <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      bus.Busy   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!valid_q || (bus.Data != shadow_q))
            state_q <= LOAD;
        end
        LOAD: begin
          shadow_q <= bus.Data;
          neg_q    <= data_neg;
          // -(-2^(Size-1)) wraps to 2^(Size-1), which is the right magnitude.
          mag_q    <= data_neg ? ((~bus.Data) + Size'(1)) : bus.Data;
          bcd_q    <= '0;
          cnt_q    <= '0;
          bus.Busy <= 1'b1;
          state_q  <= SHIFT;
        end
        SHIFT: begin
          {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(Size - 1))
            state_q <= COMMIT;
        end
        COMMIT: begin
          disp_bcd_q <= bcd_q;
          disp_neg_q <= neg_q;
          valid_q    <= 1'b1;
          bus.Busy   <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PreW'(Tick - 1)) begin
      pre_q <= '0;
      if (idx_q == IdxW'(Digits - 1))
        idx_q <= '0;
      else
        idx_q <= idx_q + IdxW'(1);
    end else begin
      pre_q <= pre_q + PreW'(1);
    end
  end

  // Digit 0 is never blanked, so zero still reads "0".
  always_comb begin
    lz_mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int i = NumDig - 1; i > 0; i--) begin
        zero_run   = zero_run && (disp_bcd_q[4*i +: 4] == 4'd0);
        lz_mask[i] = zero_run;
      end
    end
`endif
  end

  always_comb begin
    seg_sel = 7'h7F;
    for (int i = 0; i < NumDig; i++) begin
      if ((idx_q == IdxW'(i)) && !lz_mask[i])
        seg_sel = seg_of(disp_bcd_q[4*i +: 4]);
    end
    if (IsSigned && (idx_q == IdxW'(Digits - 1)))
      seg_sel = disp_neg_q ? 7'b0111111 : 7'h7F;
  end

  // Segments and Anodes come from the same index on the same edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus.Segments <= 7'h7F;
      bus.Anodes   <= '1;
    end else if (valid_q) begin
      bus.Segments <= seg_sel;
      bus.Anodes   <= ~(Digits'(1) << idx_q);
    end else begin
      bus.Segments <= 7'h7F;
      bus.Anodes   <= '1;
    end
  end

endmodule

// File: tb/tb_data_to_segments.sv
// Bench for data_to_segments: signed and unsigned instances on one Data bus,
// scoreboard of expected digit patterns popped at each finished conversion.
module tb_data_to_segments;

  localparam int Size   = 5;
  localparam int Digits = 3;
  localparam int Tick   = 5;

  typedef struct packed {
    logic [20:0] s;
    logic [20:0] u;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb[$];

  always #10 Clock = ~Clock;

  data_to_segments_if #(.Size(Size), .Digits(Digits)) bus_s ();
  data_to_segments_if #(.Size(Size), .Digits(Digits)) bus_u ();

  assign bus_u.Data = bus_s.Data;

  data_to_segments #(
    .Size(Size), .Signed("Yes"), .Digits(Digits),
    .ClockPeriod_ns(20), .RefreshPeriod_ns(100)
  ) dut_s (
    .Clock(Clock), .Reset(Reset), .bus(bus_s)
  );

  data_to_segments #(
    .Size(Size), .Signed("No"), .Digits(Digits),
    .ClockPeriod_ns(20), .RefreshPeriod_ns(100)
  ) dut_u (
    .Clock(Clock), .Reset(Reset), .bus(bus_u)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int n);
    case (n)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [20:0] model(input logic [4:0] d, input bit sgn);
    int v;
    int mag;
    int n [3];
    logic [6:0] g [3];
    v   = sgn ? int'($signed(d)) : int'(d);
    mag = (v < 0) ? -v : v;
    n[0] = mag % 10;
    n[1] = (mag / 10) % 10;
    n[2] = (mag / 100) % 10;
    for (int i = 0; i < 3; i++) g[i] = enc(n[i]);
    if (sgn) g[2] = (v < 0) ? 7'b0111111 : 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      int top;
      top = sgn ? 1 : 2;
      for (int i = top; i > 0; i--) begin
        if (n[i] != 0) break;
        g[i] = 7'h7F;
      end
    end
`endif
    return {g[2], g[1], g[0]};
  endfunction

  task automatic push_exp(input logic [4:0] d);
    exp_t e;
    e.s = model(d, 1'b1);
    e.u = model(d, 1'b0);
    sb.push_back(e);
  endtask

  task automatic wait_busy(input logic lvl, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (bus_s.Busy === lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clock);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " seg_s"}, bus_s.Segments, 7'h7F);
    check({tag, " an_s"}, bus_s.Anodes, 3'b111);
    check({tag, " busy_s"}, bus_s.Busy, 1'b0);
    check({tag, " seg_u"}, bus_u.Segments, 7'h7F);
    check({tag, " an_u"}, bus_u.Anodes, 3'b111);
    check({tag, " busy_u"}, bus_u.Busy, 1'b0);
  endtask

  task automatic read_both(output logic [20:0] ds, output logic [20:0] du,
                           output int seen_s, output int seen_u,
                           output int bad);
    logic [2:0] sel;
    ds = '1;
    du = '1;
    seen_s = 0;
    seen_u = 0;
    bad = 0;
    repeat (2) @(negedge Clock);
    for (int c = 0; c < (Digits + 1) * Tick; c++) begin
      int hit_s;
      int hit_u;
      hit_s = 0;
      hit_u = 0;
      for (int i = 0; i < Digits; i++) begin
        sel = 3'b001 << i;
        if (bus_s.Anodes === ~sel) begin
          ds[7*i +: 7] = bus_s.Segments;
          seen_s |= (1 << i);
          hit_s = 1;
        end
        if (bus_u.Anodes === ~sel) begin
          du[7*i +: 7] = bus_u.Segments;
          seen_u |= (1 << i);
          hit_u = 1;
        end
      end
      if (hit_s == 0 || hit_u == 0) bad++;
      @(negedge Clock);
    end
  endtask

  task automatic pop_and_compare(input string tag);
    logic [20:0] ds;
    logic [20:0] du;
    int ss;
    int su;
    int bad;
    exp_t e;
    read_both(ds, du, ss, su, bad);
    check({tag, " sb_nonempty"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " disp_s"}, ds, e.s);
      check({tag, " disp_u"}, du, e.u);
    end
    check({tag, " scan_seen_s"}, ss, 7);
    check({tag, " scan_seen_u"}, su, 7);
    check({tag, " anode_onehot"}, bad, 0);
  endtask

  task automatic run_conv(input string tag, input bit check_blank_an);
    bit ok;
    int hi_s;
    int hi_u;
    wait_busy(1'b1, 20, ok);
    check({tag, " busy_rise"}, ok, 1'b1);
    if (check_blank_an) begin
      check({tag, " an_blank_s"}, bus_s.Anodes, 3'b111);
      check({tag, " an_blank_u"}, bus_u.Anodes, 3'b111);
    end
    hi_s = 0;
    hi_u = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus_s.Busy !== 1'b1 && bus_u.Busy !== 1'b1) break;
      if (bus_s.Busy === 1'b1) hi_s++;
      if (bus_u.Busy === 1'b1) hi_u++;
      @(negedge Clock);
    end
    check({tag, " busy_len_s"}, hi_s, Size + 1);
    check({tag, " busy_len_u"}, hi_u, Size + 1);
    pop_and_compare(tag);
  endtask

  task automatic apply(input logic [4:0] d, input string tag);
    @(negedge Clock);
    bus_s.Data = d;
    push_exp(d);
    run_conv(tag, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  prev;
    logic [2:0]  sel;
    logic [4:0]  vals [5];
    bit          ok;
    int          gap;
    int          di;
    exp_t        e;

    Reset = 1'b1;
    bus_s.Data = 5'b00111;
    #15;
    check_reset_outputs("reset");
    push_exp(5'b00111);
    @(negedge Clock);
    Reset = 1'b0;
    run_conv("pos7", 1'b1);

    // Scan order and per-digit on-time.
    prev = bus_s.Anodes;
    gap = 0;
    while (bus_s.Anodes === prev && gap < 20) begin
      @(negedge Clock);
      gap++;
    end
    check("scan_sync", gap < 20, 1'b1);
    for (int k = 0; k < 4; k++) begin
      prev = bus_s.Anodes;
      gap = 0;
      while (bus_s.Anodes === prev && gap < 20) begin
        @(negedge Clock);
        gap++;
      end
      check($sformatf("scan_gap%0d", k), gap, Tick);
      check($sformatf("scan_next%0d", k), bus_s.Anodes,
            {prev[1:0], prev[2]});
    end

    vals = '{5'b10000, 5'b11111, 5'b01111, 5'b00000, 5'b10101};
    for (int k = 0; k < 5; k++)
      apply(vals[k], $sformatf("val_%b", vals[k]));

    // Second change lands while the first conversion is running.
    @(negedge Clock);
    bus_s.Data = 5'd3;
    push_exp(5'd3);
    push_exp(5'd12);
    wait_busy(1'b1, 20, ok);
    check("quick busy1_rise", ok, 1'b1);
    @(negedge Clock);
    bus_s.Data = 5'd12;
    wait_busy(1'b0, 20, ok);
    check("quick busy1_fall", ok, 1'b1);
    @(negedge Clock);
    di = -1;
    for (int i = 0; i < Digits; i++) begin
      sel = 3'b001 << i;
      if (bus_s.Anodes === ~sel) di = i;
    end
    check("quick mid_sel", di >= 0, 1'b1);
    check("quick sb_mid", sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (di >= 0) begin
        check("quick mid_s", bus_s.Segments, e.s[7*di +: 7]);
        check("quick mid_u", bus_u.Segments, e.u[7*di +: 7]);
      end
    end
    wait_busy(1'b1, 20, ok);
    check("quick busy2_rise", ok, 1'b1);
    wait_busy(1'b0, 20, ok);
    check("quick busy2_fall", ok, 1'b1);
    wait_busy(1'b1, 30, ok);
    check("quick no_busy3", ok, 1'b0);
    pop_and_compare("quick final");

    // Reset in the middle of SHIFT, then full reconversion.
    @(negedge Clock);
    bus_s.Data = 5'b01010;
    wait_busy(1'b1, 20, ok);
    check("rst busy_rise", ok, 1'b1);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_outputs("rst_shift");
    push_exp(5'b01010);
    @(negedge Clock);
    Reset = 1'b0;
    run_conv("after_rst", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
